uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter_if.sv | 13 +
 rtl/uart_transmitter.sv | 84 ++++++++
 tb/tb_uart_transmitter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: tick, request, payload and serial-line signals of the UART transmitter
interface uart_transmitter_if #(
    parameter int DBIT = 8
) ();
    logic            s_tick;
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx;
    logic            tx_busy;
    logic            tx_done_tick;
    modport master (output s_tick, tx_start, din, input tx, tx_busy, tx_done_tick);
    modport slave (input s_tick, tx_start, din, output tx, tx_busy, tx_done_tick);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: 16x-oversampled UART frame serializer with optional parity and 1/1.5/2 stop bits
module uart_transmitter #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input logic               clk,
    input logic               rst,
    uart_transmitter_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    logic [2:0]      r_state, w_state;
    logic [4:0]      r_s, w_s;
    logic [2:0]      r_n, w_n;
    logic [DBIT-1:0] r_b, w_b;
    logic            r_par, w_par;
    logic            r_tx, w_tx;
    logic            w_bit_end;
    assign w_bit_end        = bus.s_tick && (r_s == 5'd15);
    assign bus.tx           = r_tx;
    assign bus.tx_busy      = (r_state != IDLE);
    assign bus.tx_done_tick = (r_state == STOP) && bus.s_tick && (r_s == 5'(SB_TICK - 1));
    // next-state logic; tx is computed from the next state so the line comes straight from a flop
    always_comb begin
        w_state = r_state;
        w_s     = r_s;
        w_n     = r_n;
        w_b     = r_b;
        w_par   = r_par;
        case (r_state)
            IDLE: if (bus.tx_start) begin
                w_state = START;
                w_s     = 5'd0;
                w_b     = bus.din;
                w_par   = (PARITY == 2) ? ~^bus.din : ^bus.din;
            end
            START: if (w_bit_end) begin
                w_state = DATA;
                w_s     = 5'd0;
                w_n     = 3'd0;
            end else if (bus.s_tick) w_s = r_s + 5'd1;
            DATA: if (w_bit_end) begin
                w_s = 5'd0;
                w_b = r_b >> 1;
                if (r_n == 3'(DBIT - 1)) w_state = (PARITY != 0) ? PAR : STOP;
                else w_n = r_n + 3'd1;
            end else if (bus.s_tick) w_s = r_s + 5'd1;
            PAR: if (w_bit_end) begin
                w_state = STOP;
                w_s     = 5'd0;
            end else if (bus.s_tick) w_s = r_s + 5'd1;
            STOP: if (bus.s_tick && r_s == 5'(SB_TICK - 1)) begin
                w_state = IDLE;
                w_s     = 5'd0;
            end else if (bus.s_tick) w_s = r_s + 5'd1;
            default: w_state = IDLE;
        endcase
        w_tx = (w_state == START) ? 1'b0 :
               (w_state == DATA)  ? w_b[0] :
               (w_state == PAR)   ? w_par : 1'b1;
    end
    // state registers; reset aborts any frame and forces the line idle at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_s     <= 5'd0;
            r_n     <= 3'd0;
            r_b     <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state;
            r_s     <= w_s;
            r_n     <= w_n;
            r_b     <= w_b;
            r_par   <= w_par;
            r_tx    <= w_tx;
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: four configurations driven in parallel, each checked tick by tick against a frame model
module tb_uart_transmitter;
    logic       clk;
    logic       rst;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din_v [4];
    logic       tx_w [4];
    logic       busy_w [4];
    logic       done_w [4];
    int         cfg_d [4]  = '{8, 8, 8, 7};
    int         cfg_sb [4] = '{16, 24, 16, 32};
    int         cfg_p [4]  = '{0, 1, 2, 0};
    int         n_cmp = 0;
    int         n_bad = 0;
    int         frames [4] = '{0, 0, 0, 0};
    int         base [4];
    int         tick [4];
    int         bad [4];
    int         gap [4] = '{0, 0, 0, 0};
    int         last_gap [4] = '{0, 0, 0, 0};
    int         idle_bad = 0;
    logic [7:0] cap [4];
    logic [7:0] exp_din [4];
    bit         active [4] = '{0, 0, 0, 0};

    uart_transmitter_if #(.DBIT(8)) b0 ();
    uart_transmitter_if #(.DBIT(8)) b1 ();
    uart_transmitter_if #(.DBIT(8)) b2 ();
    uart_transmitter_if #(.DBIT(7)) b3 ();

    uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    uart_transmitter #(.DBIT(8), .SB_TICK(24), .PARITY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    uart_transmitter #(.DBIT(7), .SB_TICK(32), .PARITY(0)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    assign b0.s_tick = s_tick;
    assign b1.s_tick = s_tick;
    assign b2.s_tick = s_tick;
    assign b3.s_tick = s_tick;
    assign b0.tx_start = tx_start;
    assign b1.tx_start = tx_start;
    assign b2.tx_start = tx_start;
    assign b3.tx_start = tx_start;
    assign b0.din = din_v[0];
    assign b1.din = din_v[1];
    assign b2.din = din_v[2];
    assign b3.din = din_v[3][6:0];
    assign tx_w[0] = b0.tx;
    assign tx_w[1] = b1.tx;
    assign tx_w[2] = b2.tx;
    assign tx_w[3] = b3.tx;
    assign busy_w[0] = b0.tx_busy;
    assign busy_w[1] = b1.tx_busy;
    assign busy_w[2] = b2.tx_busy;
    assign busy_w[3] = b3.tx_busy;
    assign done_w[0] = b0.tx_done_tick;
    assign done_w[1] = b1.tx_done_tick;
    assign done_w[2] = b2.tx_done_tick;
    assign done_w[3] = b3.tx_done_tick;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int frame_len(input int i);
        return 16 + 16 * cfg_d[i] + ((cfg_p[i] != 0) ? 16 : 0) + cfg_sb[i];
    endfunction

    function automatic logic [7:0] dmask(input int i);
        return 8'((1 << cfg_d[i]) - 1);
    endfunction

    // expected line level at tick j of a frame: start, data LSB first, optional parity, then stop
    function automatic logic exp_tx(input int i, input int j, input logic [7:0] d);
        int   k;
        logic pb;
        k  = j;
        pb = ^d;
        if (k < 16) return 1'b0;
        k = k - 16;
        if (k < 16 * cfg_d[i]) return d[3'(k / 16)];
        k = k - 16 * cfg_d[i];
        if (cfg_p[i] != 0 && k < 16) return (cfg_p[i] == 1) ? pb : ~pb;
        return 1'b1;
    endfunction

    // s_tick: one-clk pulse every fourth clk
    initial begin
        int k;
        k = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            k++;
            s_tick = (k % 4 == 0);
        end
    end

    // acceptance model: a request is taken only by an idle transmitter out of reset
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (rst && tx_start && !busy_w[i]) exp_din[i] = din_v[i] & dmask(i);
    end

    // frame monitor: compares every tick of every frame with the model
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (!rst) active[i] = 0;
            else if (busy_w[i]) begin
                if (!active[i]) begin
                    active[i] = 1;
                    tick[i] = 0;
                    bad[i] = 0;
                    cap[i] = 8'h00;
                    last_gap[i] = gap[i];
                end
                gap[i] = 0;
                if (s_tick) begin
                    if (tx_w[i] !== exp_tx(i, tick[i], exp_din[i])) bad[i]++;
                    if (done_w[i] !== (tick[i] == frame_len(i) - 1)) bad[i]++;
                    if (tick[i] >= 16 && tick[i] < 16 + 16 * cfg_d[i] && tick[i] % 16 == 8)
                        cap[i][3'((tick[i] - 16) / 16)] = tx_w[i];
                    if (done_w[i] === 1'b1) begin
                        check($sformatf("d%0d_len", i), tick[i] + 1, frame_len(i));
                        check($sformatf("d%0d_ticks", i), bad[i], 0);
                        check($sformatf("d%0d_data", i), int'(cap[i]), int'(exp_din[i]));
                        frames[i]++;
                    end
                    tick[i]++;
                end else if (done_w[i] !== 1'b0) bad[i]++;
            end else begin
                active[i] = 0;
                gap[i]++;
                if (tx_w[i] !== 1'b1 || done_w[i] !== 1'b0) idle_bad++;
            end
        end
    end

    task automatic snap();
        for (int i = 0; i < 4; i++) base[i] = frames[i];
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int k, input int limit);
        bit ok;
        for (int c = 0; c < limit; c++) begin
            @(posedge clk);
            ok = 1;
            for (int i = 0; i < 4; i++) if (frames[i] < base[i] + k) ok = 0;
            if (ok) return;
        end
        check("frame_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int limit);
        bit idle;
        for (int c = 0; c < limit; c++) begin
            @(posedge clk);
            idle = 1;
            for (int i = 0; i < 4; i++) if (busy_w[i] !== 1'b0) idle = 0;
            if (idle) return;
        end
        check("idle_timeout", 0, 1);
    endtask

    task automatic frame_all(input logic [7:0] d);
        for (int i = 0; i < 4; i++) din_v[i] = d;
        snap();
        pulse_start();
        wait_done(1, 2000);
        wait_idle(2000);
    endtask

    initial begin
        logic [7:0] dirs [3] = '{8'hA5, 8'h07, 8'h41};
        rst = 1'b0;
        tx_start = 1'b0;
        for (int i = 0; i < 4; i++) din_v[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("d%0d_rst_tx", i), int'(tx_w[i]), 1);
            check($sformatf("d%0d_rst_busy", i), int'(busy_w[i]), 0);
            check($sformatf("d%0d_rst_done", i), int'(done_w[i]), 0);
        end
        rst = 1'b1;
        repeat (5) @(posedge clk);
        for (int f = 0; f < 3; f++) frame_all(dirs[f]);
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++) din_v[i] = 8'($urandom);
            snap();
            pulse_start();
            wait_done(1, 2000);
            wait_idle(2000);
            repeat ($urandom_range(0, 7)) @(posedge clk);
        end
        for (int i = 0; i < 4; i++) din_v[i] = 8'h3C;
        snap();
        pulse_start();
        repeat (120) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) din_v[i] = 8'hFF;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        wait_done(1, 2000);
        repeat (1000) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("d%0d_ignored_frames", i), frames[i] - base[i], 1);
            check($sformatf("d%0d_ignored_busy", i), int'(busy_w[i]), 0);
        end
        for (int i = 0; i < 4; i++) din_v[i] = 8'h55;
        snap();
        @(posedge clk);
        #1;
        tx_start = 1'b1;
        wait_done(2, 4000);
        #1;
        tx_start = 1'b0;
        for (int i = 0; i < 4; i++) check($sformatf("d%0d_b2b_gap", i), last_gap[i], 1);
        wait_idle(2000);
        for (int i = 0; i < 4; i++) din_v[i] = 8'($urandom);
        snap();
        pulse_start();
        repeat (288) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("d%0d_abort_tx", i), int'(tx_w[i]), 1);
            check($sformatf("d%0d_abort_busy", i), int'(busy_w[i]), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("d%0d_abort_frames", i), frames[i] - base[i], 0);
            check($sformatf("d%0d_abort_wait", i), int'(busy_w[i]), 0);
        end
        frame_all(8'h81);
        check("idle_line", idle_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
